wptr_full_ctrl: RTL

Write-side pointer and full-flag controller for the asynchronous FIFO, in the write clock domain. It sits directly upstream of the dual-clock FIFO memory:
- it accepts producer write requests and generates the gated write strobe and binary write address that drive the memory;
- it publishes a Gray-coded write pointer for synchronization into the read domain;
- it derives full, occupancy, almost-full and overflow from the read pointer that has already been synchronized into this domain.

---
 rtl/wptr_full_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-side pointer and full-flag controller for an
//                asynchronous FIFO (write clock domain). Gates producer
//                requests into a memory write strobe, keeps the binary write
//                address, publishes a Gray write pointer for the read-domain
//                synchronizer, and derives full / occupancy / almost-full /
//                overflow from the already-synchronized read pointer.
//  Optional    : WPTR_ALMOST_FULL_EN - when defined, almost_full is a real
//                registered threshold flag; otherwise it is tied low and the
//                comparator is not built.
//  Ports       : wclk           - write clock, all state on posedge
//                w_rst          - synchronous active-high reset
//                w_req          - producer write request (one word/cycle)
//                rptr_gray_sync - read pointer (Gray), synchronized to wclk
//                w_en           - memory write strobe (combinational)
//                waddr          - binary write pointer (memory uses low bits)
//                wptr_gray      - registered Gray write pointer
//                full           - registered full flag
//                wlevel         - registered occupancy, write-side view
//                almost_full    - registered almost-full flag
//                overflow       - sticky write-while-full error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl #(
    parameter int ptr_width = 9,
    parameter int AF_MARGIN = 4
) (
    input  logic                 wclk,
    input  logic                 w_rst,
    input  logic                 w_req,
    input  logic [ptr_width:0]   rptr_gray_sync,
    output logic                 w_en,
    output logic [ptr_width:0]   waddr,
    output logic [ptr_width:0]   wptr_gray,
    output logic                 full,
    output logic [ptr_width:0]   wlevel,
    output logic                 almost_full,
    output logic                 overflow
);

    // Elaboration-time sanity checks on the configuration.
    if (ptr_width < 2) begin : g_bad_ptr_width
        $error("wptr_full_ctrl: ptr_width must be >= 2");
    end
    if ((AF_MARGIN < 1) || (AF_MARGIN > (2**ptr_width) - 1)) begin : g_bad_af_margin
        $error("wptr_full_ctrl: AF_MARGIN out of range 1 .. 2**ptr_width-1");
    end

    logic [ptr_width:0] wbin_q,  wbin_d;
    logic [ptr_width:0] wgray_q, wgray_d;
    logic [ptr_width:0] wlevel_q, wlevel_d;
    logic               full_q,  full_d;
    logic               af_q,    af_d;
    logic               ovf_q,   ovf_d;

    logic               w_accept;
    logic [ptr_width:0] w_rbin;
    logic [ptr_width:0] w_full_cmp;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= ptr_width; i++) begin : g_g2b
        assign w_rbin[i] = ^rptr_gray_sync[ptr_width:i];
    end

    // Full when the next write pointer equals the read pointer with its two
    // Gray MSBs inverted (exactly one lap ahead).
    assign w_full_cmp = {~rptr_gray_sync[ptr_width:ptr_width-1],
                          rptr_gray_sync[ptr_width-2:0]};

    assign w_accept = w_req & ~full_q;

    always_comb begin
        wbin_d   = wbin_q + {{ptr_width{1'b0}}, w_accept};
        wgray_d  = (wbin_d >> 1) ^ wbin_d;
        wlevel_d = wbin_d - w_rbin;
        full_d   = (wgray_d == w_full_cmp);
        ovf_d    = ovf_q | (w_req & full_q);
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [ptr_width:0] c_af_thresh = (ptr_width+1)'((2**ptr_width) - AF_MARGIN);
    always_comb begin
        af_d = (wlevel_d >= c_af_thresh);
    end
`else
    always_comb begin
        af_d = 1'b0;
    end
`endif

    always_ff @(posedge wclk) begin
        if (w_rst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // Reset masks the strobe so a burst in flight never reaches memory.
    assign w_en        = w_req & ~full_q & ~w_rst;
    assign waddr       = wbin_q;
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign wlevel      = wlevel_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire
